reg_write_scheduler: RTL and testbench
======================================

REG_WRITE_SCHEDULER -- requirements
Module: reg_write_scheduler

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 alu_valid, mem_valid, md_valid  input  1 each  writeback request from ALU, load unit, mul/div unit.
REQ-004 alu_reg, mem_reg, md_reg  input  5 each  destination register index.
REQ-005 alu_data, mem_data, md_data  input  32 each  writeback value.
REQ-006 alu_ready, mem_ready, md_ready  output  1 each  grant; transfer = valid && ready in same cycle.
REQ-007 sig_reg_write, write_reg, write_data  output  1/5/32  register-file write port 1, registered.
REQ-008 sig_reg_write2, write_reg2, write_data2  output  1/5/32  register-file write port 2, registered.
REQ-009 alloc_valid  input  1  issue stage reserving a destination register.
REQ-010 alloc_reg  input  5  register being reserved.
REQ-011 alloc_ready  output  1  reservation accepted when alloc_valid && alloc_ready.
REQ-012 read_reg1, read_reg2  input  5 each  source registers under hazard check.
REQ-013 busy1, busy2  output  1 each  source register has a pending write.
REQ-014 sb_err  output  1  sticky: write issued to a register with zero pending count.

Function
REQ-015 Requester indices SHALL be alu=0, mem=1, md=2; rotating pointer rr_ptr (2 bits, values 0..2) sets priority order rr_ptr, rr_ptr+1, rr_ptr+2 mod 3.
REQ-016 Each cycle the block SHALL grant at most two valid requesters, scanning in priority order; ready outputs are combinational from valids, regs and rr_ptr.
REQ-017 A candidate whose nonzero reg equals an already-granted candidate's reg SHALL be skipped; a later candidate with a different reg may take the remaining slot.
REQ-018 Requests to reg 0 SHALL be granted and consume a slot but produce no write-port assertion and no scoreboard change.
REQ-019 After any grant rr_ptr SHALL become (index of last granted requester + 1) mod 3; with no grant rr_ptr is unchanged.
REQ-020 First granted transfer SHALL drive port 1, second drives port 2, one cycle after the transfer (latency 1); unused ports have sig deasserted, reg/data zero.
REQ-021 Ports 1 and 2 SHALL never be asserted together with equal write_reg.
REQ-022 Scoreboard SHALL hold a 2-bit saturating pending count per register 1..31; register 0 count is constant 0.
REQ-023 alloc_ready SHALL be 1 when alloc_reg==0 or its count < 3, else 0; no bypass of same-cycle decrements.
REQ-024 An accepted alloc SHALL increment the count of alloc_reg (nonzero); each asserted write port SHALL decrement the count of its write_reg.
REQ-025 Simultaneous increment and decrement of the same register SHALL leave its count unchanged.
REQ-026 Decrement of a zero count SHALL leave it 0 and set sb_err, which stays 1 until reset.
REQ-027 busy1/busy2 SHALL equal (count[read_regN] != 0), combinational on current counts; a read in the same cycle as the clearing write still reports busy.
REQ-028 Data and reg on the write ports SHALL be exactly the values presented at transfer, unmodified.

Reset
REQ-029 While rst=1 all ready outputs and alloc_ready SHALL be 0 and no transfer or alloc occurs.
REQ-030 On the clock edge with rst=1: rr_ptr=0, all counts 0, sb_err=0, both write ports deasserted with reg/data zero.
REQ-031 rst asserted with transfers registered but not yet on the ports SHALL discard them; no write appears after reset.

Verification
REQ-032 All three valid, regs 5/6/7, rr_ptr=0 -> alu and mem granted; next cycle port1=(5,alu_data), port2=(6,mem_data); rr_ptr=2; following cycle md granted first.
REQ-033 alu and mem both reg 9, md reg 4, rr_ptr=0 -> alu and md granted, mem_ready=0; ports (9,alu_data),(4,md_data).
REQ-034 Alloc reg 12 three times -> alloc_ready=0 for reg 12, busy1=1 with read_reg1=12; three writes to 12 -> count 0, busy1=0, sb_err=0.
REQ-035 Alloc reg 3 and write to reg 3 same cycle with count 1 -> count stays 1; busy remains 1.
REQ-036 Write to reg 20 with count 0 -> sb_err=1, held until rst; mem request to reg 0 -> mem_ready=1, no port asserted.
REQ-037 rst pulsed one cycle after a grant -> ports deasserted next cycle, counts 0, rr_ptr=0.

Source files
------------

// File: rtl/reg_write_scheduler.sv
// Writeback scheduler: picks up to two of three writeback requesters per cycle
// for a dual-write-port register file and tracks pending writes per register.
module reg_write_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic        mem_valid,
  input  logic        md_valid,
  input  logic [4:0]  alu_reg,
  input  logic [4:0]  mem_reg,
  input  logic [4:0]  md_reg,
  input  logic [31:0] alu_data,
  input  logic [31:0] mem_data,
  input  logic [31:0] md_data,
  output logic        alu_ready,
  output logic        mem_ready,
  output logic        md_ready,
  output logic        sig_reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        sig_reg_write2,
  output logic [4:0]  write_reg2,
  output logic [31:0] write_data2,
  input  logic        alloc_valid,
  input  logic [4:0]  alloc_reg,
  output logic        alloc_ready,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  output logic        busy1,
  output logic        busy2,
  output logic        sb_err
);

  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [31:0][1:0]  cnt_q, cnt_d;
  logic              sb_err_q, sb_err_d;
  logic              wr1_q, wr1_d, wr2_q, wr2_d;
  logic [4:0]        wreg1_q, wreg1_d, wreg2_q, wreg2_d;
  logic [31:0]       wdata1_q, wdata1_d, wdata2_q, wdata2_d;

  logic [2:0]        req_valid;
  logic [2:0][4:0]   req_reg;
  logic [2:0][31:0]  req_data;
  logic [2:0]        rdy;
  logic              alloc_fire;

  assign req_valid = {md_valid, mem_valid, alu_valid};
  assign req_reg   = {md_reg, mem_reg, alu_reg};
  assign req_data  = {md_data, mem_data, alu_data};

  function automatic logic [1:0] prio_idx(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

  // Grant selection: scan requesters in rotating priority order, at most two slots.
  always_comb begin
    logic [1:0] idx;
    logic [1:0] n_grant;
    logic [4:0] first_reg;
    logic [1:0] last_idx;
    logic       any_grant;
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    rdy       = '0;
    n_grant   = '0;
    first_reg = '0;
    last_idx  = rr_ptr_q;
    any_grant = 1'b0;
    idx       = '0;
    wr1_d = 1'b0; wreg1_d = '0; wdata1_d = '0;
    wr2_d = 1'b0; wreg2_d = '0; wdata2_d = '0;
    for (int k = 0; k < 3; k++) begin
      idx = prio_idx(rr_ptr_q, 2'(k));
      if (!rst && req_valid[idx] && (n_grant != 2'd2) &&
          !((n_grant == 2'd1) && (req_reg[idx] != 5'd0) && (req_reg[idx] == first_reg))) begin
        rdy[idx] = 1'b1;
        if (n_grant == 2'd0) begin
          first_reg = req_reg[idx];
          if (req_reg[idx] != 5'd0) begin
            wr1_d    = 1'b1;
            wreg1_d  = req_reg[idx];
            wdata1_d = req_data[idx];
          end
        end else if (req_reg[idx] != 5'd0) begin
          wr2_d    = 1'b1;
          wreg2_d  = req_reg[idx];
          wdata2_d = req_data[idx];
        end
        n_grant   = n_grant + 2'd1;
        last_idx  = idx;
        any_grant = 1'b1;
      end
    end
    rr_ptr_d = any_grant ? ((last_idx == 2'd2) ? 2'd0 : last_idx + 2'd1) : rr_ptr_q;
  end

  assign alu_ready = rdy[0];
  assign mem_ready = rdy[1];
  assign md_ready  = rdy[2];

  assign alloc_ready = !rst && ((alloc_reg == 5'd0) || (cnt_q[alloc_reg] != 2'd3));
  assign alloc_fire  = alloc_valid && alloc_ready && (alloc_reg != 5'd0);

  // Scoreboard: reservations increment, registered write ports decrement.
  always_comb begin
    logic inc;
    logic dec;
    cnt_d    = cnt_q;
    cnt_d[0] = 2'd0;
    sb_err_d = sb_err_q;
    inc      = 1'b0;
    dec      = 1'b0;
    for (int r = 1; r < 32; r++) begin
      inc = alloc_fire && (alloc_reg == 5'(r));
      dec = (wr1_q && (wreg1_q == 5'(r))) || (wr2_q && (wreg2_q == 5'(r)));
      if (dec && (cnt_q[r] == 2'd0)) sb_err_d = 1'b1;
      if (inc && !dec) begin
        cnt_d[r] = (cnt_q[r] == 2'd3) ? 2'd3 : cnt_q[r] + 2'd1;
      end else if (dec && !inc && (cnt_q[r] != 2'd0)) begin
        cnt_d[r] = cnt_q[r] - 2'd1;
      end
    end
  end

  // NOTE: the pending counts are reset like any other state; a stale count would raise false hazards.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      sb_err_q <= 1'b0;
      wr1_q    <= 1'b0;
      wreg1_q  <= '0;
      wdata1_q <= '0;
      wr2_q    <= 1'b0;
      wreg2_q  <= '0;
      wdata2_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
      wr1_q    <= wr1_d;
      wreg1_q  <= wreg1_d;
      wdata1_q <= wdata1_d;
      wr2_q    <= wr2_d;
      wreg2_q  <= wreg2_d;
      wdata2_q <= wdata2_d;
    end
  end

  assign sig_reg_write  = wr1_q;
  assign write_reg      = wreg1_q;
  assign write_data     = wdata1_q;
  assign sig_reg_write2 = wr2_q;
  assign write_reg2     = wreg2_q;
  assign write_data2    = wdata2_q;
  assign busy1          = (cnt_q[read_reg1] != 2'd0);
  assign busy2          = (cnt_q[read_reg2] != 2'd0);
  assign sb_err         = sb_err_q;

endmodule

// File: tb/tb_reg_write_scheduler.sv
// Directed bench for reg_write_scheduler: one task per scenario, inline checks.
module tb_reg_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, md_valid;
  logic [4:0]  alu_reg, mem_reg, md_reg;
  logic [31:0] alu_data, mem_data, md_data;
  logic        alu_ready, mem_ready, md_ready;
  logic        sig_reg_write, sig_reg_write2;
  logic [4:0]  write_reg, write_reg2;
  logic [31:0] write_data, write_data2;
  logic        alloc_valid;
  logic [4:0]  alloc_reg;
  logic        alloc_ready;
  logic [4:0]  read_reg1, read_reg2;
  logic        busy1, busy2, sb_err;

  int tests_run    = 0;
  int tests_failed = 0;

  reg_write_scheduler dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .mem_valid(mem_valid), .md_valid(md_valid),
    .alu_reg(alu_reg), .mem_reg(mem_reg), .md_reg(md_reg),
    .alu_data(alu_data), .mem_data(mem_data), .md_data(md_data),
    .alu_ready(alu_ready), .mem_ready(mem_ready), .md_ready(md_ready),
    .sig_reg_write(sig_reg_write), .write_reg(write_reg), .write_data(write_data),
    .sig_reg_write2(sig_reg_write2), .write_reg2(write_reg2), .write_data2(write_data2),
    .alloc_valid(alloc_valid), .alloc_reg(alloc_reg), .alloc_ready(alloc_ready),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .busy1(busy1), .busy2(busy2), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    alu_valid = 1'b0; mem_valid = 1'b0; md_valid = 1'b0;
    alloc_valid = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] r);
    alloc_valid = 1'b1;
    alloc_reg   = r;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    clear_reqs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alu_valid = 1'b1; mem_valid = 1'b1; md_valid = 1'b1;
    alu_reg = 5'd1; mem_reg = 5'd2; md_reg = 5'd3;
    alloc_valid = 1'b1; alloc_reg = 5'd4;
    step(); step();
    tests_run++;
    if ({md_ready, mem_ready, alu_ready, alloc_ready} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b want 0000", {md_ready, mem_ready, alu_ready, alloc_ready});
    end
    tests_run++;
    if ({sig_reg_write, write_reg, write_data, sig_reg_write2, write_reg2, write_data2, sb_err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ports: got w1=%b r1=%0d w2=%b r2=%0d err=%b want all zero",
               sig_reg_write, write_reg, sig_reg_write2, write_reg2, sb_err);
    end
    clear_reqs();
    rst = 1'b0;
    step();
  endtask

  task automatic test_rotation();
    alloc(5'd5); alloc(5'd5); alloc(5'd6); alloc(5'd7);
    alu_valid = 1'b1; mem_valid = 1'b1; md_valid = 1'b1;
    alu_reg = 5'd5; mem_reg = 5'd6; md_reg = 5'd7;
    alu_data = 32'hA1A1_0005; mem_data = 32'hB2B2_0006; md_data = 32'hC3C3_0007;
    #1;
    tests_run++;
    if ({md_ready, mem_ready, alu_ready} !== 3'b011) begin
      tests_failed++;
      $display("FAIL rot_grant0: got %b want 011", {md_ready, mem_ready, alu_ready});
    end
    step();
    tests_run++;
    if ({sig_reg_write, write_reg, write_data} !== {1'b1, 5'd5, 32'hA1A1_0005} ||
        {sig_reg_write2, write_reg2, write_data2} !== {1'b1, 5'd6, 32'hB2B2_0006}) begin
      tests_failed++;
      $display("FAIL rot_ports0: got (%b,%0d,%h)(%b,%0d,%h) want (1,5,a1a10005)(1,6,b2b20006)",
               sig_reg_write, write_reg, write_data, sig_reg_write2, write_reg2, write_data2);
    end
    tests_run++;
    if ({md_ready, mem_ready, alu_ready} !== 3'b101) begin
      tests_failed++;
      $display("FAIL rot_grant1: got %b want 101", {md_ready, mem_ready, alu_ready});
    end
    step();
    clear_reqs();
    tests_run++;
    if ({sig_reg_write, write_reg, write_data} !== {1'b1, 5'd7, 32'hC3C3_0007} ||
        {sig_reg_write2, write_reg2, write_data2} !== {1'b1, 5'd5, 32'hA1A1_0005}) begin
      tests_failed++;
      $display("FAIL rot_ports1: got (%b,%0d,%h)(%b,%0d,%h) want (1,7,c3c30007)(1,5,a1a10005)",
               sig_reg_write, write_reg, write_data, sig_reg_write2, write_reg2, write_data2);
    end
    step();
    read_reg1 = 5'd5; read_reg2 = 5'd7;
    #1;
    tests_run++;
    if ({busy1, busy2, sb_err, sig_reg_write, sig_reg_write2} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL rot_drain: got busy=%b%b err=%b w=%b%b want 00 0 00",
               busy1, busy2, sb_err, sig_reg_write, sig_reg_write2);
    end
  endtask

  task automatic test_conflict();
    pulse_reset();
    alloc(5'd9); alloc(5'd4);
    alu_valid = 1'b1; mem_valid = 1'b1; md_valid = 1'b1;
    alu_reg = 5'd9; mem_reg = 5'd9; md_reg = 5'd4;
    alu_data = 32'h1111_0009; mem_data = 32'h2222_0009; md_data = 32'h3333_0004;
    #1;
    tests_run++;
    if ({md_ready, mem_ready, alu_ready} !== 3'b101) begin
      tests_failed++;
      $display("FAIL conflict_grant: got %b want 101", {md_ready, mem_ready, alu_ready});
    end
    step();
    clear_reqs();
    tests_run++;
    if ({sig_reg_write, write_reg, write_data} !== {1'b1, 5'd9, 32'h1111_0009} ||
        {sig_reg_write2, write_reg2, write_data2} !== {1'b1, 5'd4, 32'h3333_0004}) begin
      tests_failed++;
      $display("FAIL conflict_ports: got (%b,%0d,%h)(%b,%0d,%h) want (1,9,11110009)(1,4,33330004)",
               sig_reg_write, write_reg, write_data, sig_reg_write2, write_reg2, write_data2);
    end
    step();
    read_reg1 = 5'd9; read_reg2 = 5'd4;
    #1;
    tests_run++;
    if ({busy1, busy2, sb_err} !== 3'b000) begin
      tests_failed++;
      $display("FAIL conflict_drain: got busy=%b%b err=%b want 000", busy1, busy2, sb_err);
    end
  endtask

  task automatic test_alloc_saturate();
    read_reg1 = 5'd12;
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_reg = 5'd12;
      #1;
      tests_run++;
      if (alloc_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL alloc_accept%0d: got %b want 1", i, alloc_ready);
      end
      step();
    end
    tests_run++;
    if ({alloc_ready, busy1} !== 2'b01) begin
      tests_failed++;
      $display("FAIL alloc_full: got ready=%b busy1=%b want ready=0 busy1=1", alloc_ready, busy1);
    end
    alloc_valid = 1'b0;
    alu_valid = 1'b1; alu_reg = 5'd12; alu_data = 32'h0000_0C0C;
    repeat (3) step();
    alu_valid = 1'b0;
    step();
    tests_run++;
    if ({busy1, sb_err} !== 2'b00) begin
      tests_failed++;
      $display("FAIL alloc_drain: got busy1=%b err=%b want 00", busy1, sb_err);
    end
  endtask

  task automatic test_same_cycle();
    read_reg1 = 5'd3;
    alloc(5'd3);
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'hDEAD_0003;
    step();
    alu_valid = 1'b0;
    alloc_valid = 1'b1; alloc_reg = 5'd3;
    #1;
    tests_run++;
    if ({sig_reg_write, write_reg, busy1, alloc_ready} !== {1'b1, 5'd3, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL same_cycle_pre: got w=%b r=%0d busy1=%b ar=%b want 1 3 1 1",
               sig_reg_write, write_reg, busy1, alloc_ready);
    end
    step();
    alloc_valid = 1'b0;
    tests_run++;
    if ({busy1, sig_reg_write} !== 2'b10) begin
      tests_failed++;
      $display("FAIL same_cycle_hold: got busy1=%b w=%b want 1 0", busy1, sig_reg_write);
    end
    alu_valid = 1'b1;
    step();
    alu_valid = 1'b0;
    step();
    tests_run++;
    if ({busy1, sb_err} !== 2'b00) begin
      tests_failed++;
      $display("FAIL same_cycle_count1: got busy1=%b err=%b want 00", busy1, sb_err);
    end
  endtask

  task automatic test_err_and_reg0();
    mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'hFFFF_FFFF;
    #1;
    tests_run++;
    if ({md_ready, mem_ready, alu_ready} !== 3'b010) begin
      tests_failed++;
      $display("FAIL reg0_grant: got %b want 010", {md_ready, mem_ready, alu_ready});
    end
    step();
    mem_valid = 1'b0;
    tests_run++;
    if ({sig_reg_write, sig_reg_write2, sb_err} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reg0_noport: got w=%b%b err=%b want 000", sig_reg_write, sig_reg_write2, sb_err);
    end
    alu_valid = 1'b1; alu_reg = 5'd20; alu_data = 32'h0000_0020;
    step();
    alu_valid = 1'b0;
    step();
    repeat (3) step();
    read_reg1 = 5'd20;
    #1;
    tests_run++;
    if ({sb_err, busy1} !== 2'b10) begin
      tests_failed++;
      $display("FAIL err_sticky: got err=%b busy1=%b want 1 0", sb_err, busy1);
    end
    pulse_reset();
    tests_run++;
    if (sb_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_clear: got %b want 0", sb_err);
    end
  endtask

  task automatic test_reset_discard();
    read_reg1 = 5'd8;
    alloc(5'd8);
    alu_valid = 1'b1; alu_reg = 5'd8; alu_data = 32'h0808_0808;
    step();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({alu_ready, alloc_ready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rstd_ready: got alu=%b alloc=%b want 00", alu_ready, alloc_ready);
    end
    step();
    alu_valid = 1'b0;
    rst = 1'b0;
    tests_run++;
    if ({sig_reg_write, write_reg, write_data, sig_reg_write2, busy1} !== '0) begin
      tests_failed++;
      $display("FAIL rstd_ports: got w1=%b r1=%0d d1=%h w2=%b busy1=%b want zero",
               sig_reg_write, write_reg, write_data, sig_reg_write2, busy1);
    end
    step();
    alu_valid = 1'b1; mem_valid = 1'b1; md_valid = 1'b1;
    alu_reg = 5'd1; mem_reg = 5'd2; md_reg = 5'd3;
    #1;
    tests_run++;
    if ({md_ready, mem_ready, alu_ready, sig_reg_write, sb_err} !== 5'b01100) begin
      tests_failed++;
      $display("FAIL rstd_ptr: got rdy=%b w=%b err=%b want 011 0 0",
               {md_ready, mem_ready, alu_ready}, sig_reg_write, sb_err);
    end
    clear_reqs();
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    alu_reg = '0; mem_reg = '0; md_reg = '0;
    alu_data = '0; mem_data = '0; md_data = '0;
    alloc_reg = '0; read_reg1 = '0; read_reg2 = '0;
    test_reset();
    test_rotation();
    test_conflict();
    test_alloc_saturate();
    test_same_cycle();
    test_err_and_reg0();
    test_reset_discard();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
